// File: rtl/pipe_ctrl_chain_if.sv
// Bundle between the decode/hazard controller and the pipe_ctrl_chain register chain.
// The master drives the incoming instruction and stage controls; the slave returns per-stage taps.
interface pipe_ctrl_chain_if #(
    parameter int STAGES = 3,
    parameter int CTRL_W = 16,
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int CNT_W  = 16
) ();
    logic                     in_valid;
    logic [CTRL_W-1:0]        in_ctrl;
    logic [DATA_W-1:0]        in_data;
    logic [AW-1:0]            in_dst;
    logic                     in_ld;
    logic [AW-1:0]            in_src1;
    logic [AW-1:0]            in_src2;
    logic                     in_ready;
    logic [STAGES-1:0]        stall;
    logic [STAGES-1:0]        flush;
    logic [STAGES-1:0]        valid_tap;
    logic [STAGES*CTRL_W-1:0] ctrl_tap;
    logic [STAGES*DATA_W-1:0] data_tap;
    logic [STAGES*AW-1:0]     dst_tap;
    logic                     hazard;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output in_valid, in_ctrl, in_data, in_dst, in_ld, in_src1, in_src2,
        output stall, flush,
        input  in_ready, valid_tap, ctrl_tap, data_tap, dst_tap, hazard, stall_cnt
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, in_dst, in_ld, in_src1, in_src2,
        input  stall, flush,
        output in_ready, valid_tap, ctrl_tap, data_tap, dst_tap, hazard, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// EX..WB pipeline-register chain with per-stage stall/flush, load-use bubble insertion
// and a saturating count of cycles in which decode was held off.
module pipe_ctrl_chain #(
    parameter int STAGES = 3,
    parameter int CTRL_W = 16,
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_ctrl_chain_if.slave  bus
);

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_ld;
    logic [CTRL_W-1:0] r_ctrl [STAGES];
    logic [DATA_W-1:0] r_data [STAGES];
    logic [AW-1:0]     r_dst  [STAGES];
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [STAGES-1:0] w_hold;
    logic              w_src_match;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_stall_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (&val) begin
            return val;
        end
        return val + CNT_W'(1);
    endfunction

    // A stall anywhere downstream freezes this stage too.
    always_comb begin
        w_hold = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_hold[k] = |(bus.stall >> k);
        end
    end

    assign w_src_match = (r_dst[0] == bus.in_src1) | (r_dst[0] == bus.in_src2);
    assign w_hazard    = bus.in_valid & r_v[0] & r_ld[0] & (r_dst[0] != '0) & w_src_match;
    assign w_in_ready  = ~w_hold[0] & ~w_hazard;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_stall_evt = bus.in_valid & ~w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v         <= '0;
            r_ld        <= '0;
            r_stall_cnt <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_ctrl[k] <= '0;
                r_data[k] <= '0;
                r_dst[k]  <= '0;
            end
        end else begin
            // Stage 0: input capture; a rejected or absent instruction becomes an all-zero bubble.
            if (bus.flush[0]) begin
                r_v[0]    <= 1'b0;
                r_ld[0]   <= 1'b0;
                r_ctrl[0] <= '0;
                r_data[0] <= '0;
                r_dst[0]  <= '0;
            end else if (!w_hold[0]) begin
                r_v[0]    <= w_accept;
                r_ld[0]   <= w_accept & bus.in_ld;
                r_ctrl[0] <= w_accept ? bus.in_ctrl : '0;
                r_data[0] <= w_accept ? bus.in_data : '0;
                r_dst[0]  <= w_accept ? bus.in_dst  : '0;
            end

            // Stages 1..N-1: a held upstream neighbour hands down a bubble instead of its contents.
            for (int k = 1; k < STAGES; k++) begin
                if (bus.flush[k] || (!w_hold[k] && w_hold[k-1])) begin
                    r_v[k]    <= 1'b0;
                    r_ld[k]   <= 1'b0;
                    r_ctrl[k] <= '0;
                    r_data[k] <= '0;
                    r_dst[k]  <= '0;
                end else if (!w_hold[k]) begin
                    r_v[k]    <= r_v[k-1];
                    r_ld[k]   <= r_ld[k-1];
                    r_ctrl[k] <= r_ctrl[k-1];
                    r_data[k] <= r_data[k-1];
                    r_dst[k]  <= r_dst[k-1];
                end
            end

            if (w_stall_evt) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    logic [STAGES*CTRL_W-1:0] w_ctrl_tap;
    logic [STAGES*DATA_W-1:0] w_data_tap;
    logic [STAGES*AW-1:0]     w_dst_tap;

    always_comb begin
        w_ctrl_tap = '0;
        w_data_tap = '0;
        w_dst_tap  = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_ctrl_tap[k*CTRL_W +: CTRL_W] = r_ctrl[k];
            w_data_tap[k*DATA_W +: DATA_W] = r_data[k];
            w_dst_tap[k*AW +: AW]          = r_dst[k];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.hazard    = w_hazard;
    assign bus.valid_tap = r_v;
    assign bus.ctrl_tap  = w_ctrl_tap;
    assign bus.data_tap  = w_data_tap;
    assign bus.dst_tap   = w_dst_tap;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
